muldiv_arbiter: RTL

- Shares one combinational signed/unsigned divide unit (quotient plus remainder) between two requesters, e.g. the execute stage and a second issue slot.
- Registers the operands so they stay stable at the unit for LATENCY cycles (multicycle path), then captures the result.
- Returns the result to the owning requester under a valid/hold handshake.
- Round-robin arbitration prevents either requester from starving the other.

---
 rtl/muldiv_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: shares one combinational divide unit between two requesters.
// Operands are registered and held at the unit for LATENCY cycles (multicycle
// path), the result is captured, then returned to the owning requester under a
// valid/hold handshake. Round-robin arbitration resolves simultaneous requests.
module muldiv_arbiter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    input  logic [1:0]       req_signed,
    input  logic [WIDTH-1:0] req_numer0,
    input  logic [WIDTH-1:0] req_numer1,
    input  logic [WIDTH-1:0] req_denom0,
    input  logic [WIDTH-1:0] req_denom1,
    output logic [1:0]       req_ready,
    output logic [WIDTH-1:0] unit_numer,
    output logic [WIDTH-1:0] unit_denom,
    output logic             unit_signed,
    input  logic [WIDTH-1:0] unit_quotient,
    input  logic [WIDTH-1:0] unit_remainder,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_hold,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_div_by_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter is loaded with LATENCY-1 so the capture edge lands at E0+LATENCY.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] count_r;
    logic       owner_r;
    logic       last_grant_r;

    logic       consume_s;
    logic       can_grant_s;
    logic       grant_any_s;
    logic       grant_idx_s;
    logic       accept_s;
    logic       capture_s;

    // Grant window: idle, or the pending response is being consumed this cycle.
    always_comb begin
        consume_s   = (state_r == ST_DONE) && !rsp_hold[owner_r];
        can_grant_s = (state_r == ST_IDLE) || consume_s;
        capture_s   = (state_r == ST_RUN) && (count_r == 4'd0);
    end

    // Round-robin pick: a lone request always wins, a conflict goes to !last_grant.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = 1'b0;
        case (req_valid)
            2'b01: begin
                grant_any_s = 1'b1;
                grant_idx_s = 1'b0;
            end
            2'b10: begin
                grant_any_s = 1'b1;
                grant_idx_s = 1'b1;
            end
            2'b11: begin
                grant_any_s = 1'b1;
                grant_idx_s = ~last_grant_r;
            end
            default: begin
                grant_any_s = 1'b0;
                grant_idx_s = 1'b0;
            end
        endcase
    end

    // Ready is a pure decode of the grant, so it can only rise for a valid requester.
    always_comb begin
        req_ready = 2'b00;
        if (can_grant_s && grant_any_s) begin
            req_ready = grant_idx_s ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
        accept_s = can_grant_s && grant_any_s;
    end

    // Next-state logic for the IDLE -> RUN -> DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_RUN;
                else          state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (count_r == 4'd0) state_nxt_s = ST_DONE;
                else                 state_nxt_s = ST_RUN;
            end
            ST_DONE: begin
                if (accept_s)       state_nxt_s = ST_RUN;
                else if (consume_s) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register; busy is registered from the next state so it tracks state_r.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s != ST_IDLE);
        end
    end

    // Latency counter, owner and round-robin pointer (requester 0 wins first conflict).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r      <= 4'd0;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            count_r      <= CNT_INIT;
            owner_r      <= grant_idx_s;
            last_grant_r <= grant_idx_s;
        end else if ((state_r == ST_RUN) && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end
    end

    // Operand launch registers: change only at acceptance edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            unit_numer  <= {WIDTH{1'b0}};
            unit_denom  <= {WIDTH{1'b0}};
            unit_signed <= 1'b0;
        end else if (accept_s) begin
            unit_numer  <= grant_idx_s ? req_numer1 : req_numer0;
            unit_denom  <= grant_idx_s ? req_denom1 : req_denom0;
            unit_signed <= req_signed[grant_idx_s];
        end
    end

    // Response registers: capture at the end of RUN, clear valid on consumption.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid       <= 2'b00;
            rsp_quotient    <= {WIDTH{1'b0}};
            rsp_remainder   <= {WIDTH{1'b0}};
            rsp_div_by_zero <= 1'b0;
        end else if (capture_s) begin
            rsp_valid <= owner_r ? 2'b10 : 2'b01;
            if (unit_denom == {WIDTH{1'b0}}) begin
                // Divide by zero: unit output is ignored, fixed result pattern.
                rsp_quotient    <= {WIDTH{1'b1}};
                rsp_remainder   <= unit_numer;
                rsp_div_by_zero <= 1'b1;
            end else begin
                rsp_quotient    <= unit_quotient;
                rsp_remainder   <= unit_remainder;
                rsp_div_by_zero <= 1'b0;
            end
        end else if (consume_s) begin
            rsp_valid <= 2'b00;
        end
    end

endmodule
